// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing single-port DataMemory between m0 (LSU) and m1 (debug/DMA), plus zero-fill clear engine.
// Latency: grant is combinational and the access completes at that posedge; read data/rvalid appear 1 cycle later.
// Backpressure: a master holds req and fields until gnt; no grants while the clear engine owns the memory.
module dmem_port_arbiter #(
    parameter int MEM_WIDTH     = 32,
    parameter int MEM_DEPTH     = 100,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [MEM_WIDTH-1:0]     m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [MEM_WIDTH-1:0]     m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [MEM_WIDTH-1:0]     m1_wdata,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [MEM_WIDTH-1:0]     m1_rdata,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]     mem_wd,
    output logic                     mem_wen,
    input  logic [MEM_WIDTH-1:0]     mem_rd
);

    localparam int CNT_W = $clog2(MEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             prio, prio_nxt;
    logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
    logic             clr_done_nxt;

    assign clr_busy = (state == CLEAR);

    // Next-state, arbitration and memory pin drive; prio always points at the master not served last.
    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        clr_cnt_nxt  = clr_cnt;
        clr_done_nxt = 1'b0;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        mem_addr     = '0;
        mem_wd       = '0;
        mem_wen      = 1'b0;
        case (state)
            RUN: begin
                if (m0_req && (!m1_req || !prio)) begin
                    m0_gnt   = 1'b1;
                    prio_nxt = 1'b1;
                    mem_addr = m0_addr;
                    mem_wd   = m0_wdata;
                    mem_wen  = m0_we;
                end else if (m1_req) begin
                    m1_gnt   = 1'b1;
                    prio_nxt = 1'b0;
                    mem_addr = m1_addr;
                    mem_wd   = m1_wdata;
                    mem_wen  = m1_we;
                end
                // A grant in the same cycle as clr_start still completes before the fill begins.
                if (clr_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                mem_wen  = 1'b1;
                mem_addr = ADDRESS_WIDTH'(clr_cnt);
                if (clr_cnt == CNT_LAST) begin
                    state_nxt    = RUN;
                    clr_cnt_nxt  = '0;
                    clr_done_nxt = 1'b1;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = RUN;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // State, counters and registered read responses; reset abandons any clear in progress.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state     <= RUN;
            prio      <= 1'b0;
            clr_cnt   <= '0;
            clr_done  <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            clr_cnt   <= clr_cnt_nxt;
            clr_done  <= clr_done_nxt;
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= mem_rd;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural DataMemory, transaction-level reference model and read-data scoreboard.
// Directed scenarios (write/read, alternation, priority, clear, clear with held req, reset mid-clear) then random traffic.
// Model predicts grants/memory pins per cycle and queues expected read data; a separate monitor pops on rvalid.
module tb_dmem_port_arbiter;

    localparam int W  = 32;
    localparam int D  = 100;
    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [W-1:0]  m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [W-1:0]  m0_rdata, m1_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wd, mem_rd;
    logic          mem_wen;

    always #5 CLK = ~CLK;

    dmem_port_arbiter #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDRESS_WIDTH(AW)) dut (
        .CLK(CLK), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_wen(mem_wen), .mem_rd(mem_rd)
    );

    // Behavioural DataMemory: asynchronous read, write at posedge.
    logic [W-1:0] mem [0:D-1];
    assign mem_rd = (mem_addr < AW'(D)) ? mem[mem_addr[6:0]] : '0;
    always @(posedge CLK) if (mem_wen && mem_addr < AW'(D)) mem[mem_addr[6:0]] <= mem_wd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] ref_mem [0:D-1];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit chk_en = 0;
    bit m_clear = 0;
    int m_left = 0;
    int m_fav = 0;
    bit m_done = 0;

    always @(negedge CLK) begin : model
        int win;
        logic [AW-1:0] ea;
        logic [W-1:0] ewd;
        logic ewen;
        if (chk_en) begin
            win = -1; ea = '0; ewd = '0; ewen = 1'b0;
            chk("clr_busy", 32'(clr_busy), 32'(m_clear));
            chk("clr_done", 32'(clr_done), 32'(m_done));
            if (m_clear) begin
                ea = AW'(D - m_left);
                ewen = 1'b1;
            end else if (m0_req && m1_req) win = m_fav;
            else if (m0_req) win = 0;
            else if (m1_req) win = 1;
            if (win == 0) begin ea = m0_addr; ewd = m0_wdata; ewen = m0_we; end
            if (win == 1) begin ea = m1_addr; ewd = m1_wdata; ewen = m1_we; end
            chk("m0_gnt", 32'(m0_gnt), 32'(win == 0));
            chk("m1_gnt", 32'(m1_gnt), 32'(win == 1));
            chk("mem_addr", mem_addr, ea);
            chk("mem_wd", mem_wd, ewd);
            chk("mem_wen", 32'(mem_wen), 32'(ewen));
            if (m_clear) ref_mem[ea[6:0]] = '0;
            else if (win >= 0) begin
                if (ewen) ref_mem[ea[6:0]] = ewd;
                else if (rst) begin
                    if (win == 0) q0.push_back(ref_mem[ea[6:0]]);
                    else q1.push_back(ref_mem[ea[6:0]]);
                end
            end
            if (!rst) begin
                m_clear = 0; m_fav = 0; m_done = 0;
            end else if (m_clear) begin
                m_left--;
                m_done = (m_left == 0);
                if (m_left == 0) m_clear = 0;
            end else begin
                m_done = 0;
                if (win >= 0) m_fav = (win == 0) ? 1 : 0;
                if (clr_start) begin m_clear = 1; m_left = D; end
            end
        end
    end

    // Monitor: each queued read must produce exactly one rvalid the following cycle with matching data.
    always @(posedge CLK) begin
        #3;
        if (chk_en) begin
            chk("m0_rvalid", 32'(m0_rvalid), 32'(q0.size() != 0));
            if (m0_rvalid && q0.size() != 0) chk("m0_rdata", m0_rdata, q0.pop_front());
            chk("m1_rvalid", 32'(m1_rvalid), 32'(q1.size() != 0));
            if (m1_rvalid && q1.size() != 0) chk("m1_rdata", m1_rdata, q1.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic access(input int m, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        bit got;
        got = 0;
        if (m == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
        else begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if ((m == 0) ? m0_gnt : m1_gnt) begin got = 1; break; end
        end
        tick();
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL gnt_timeout: master %0d got no grant, expected one", m);
        end
    endtask

    task automatic read_chk(input int m, input logic [AW-1:0] a, input logic [W-1:0] exp);
        access(m, 1'b0, a, $urandom);
        chk("rd_rvalid", 32'((m == 0) ? m0_rvalid : m1_rvalid), 32'd1);
        chk("rd_data", (m == 0) ? m0_rdata : m1_rdata, exp);
    endtask

    task automatic pulse_clear();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
    endtask

    initial begin
        int cnt, dn;
        bit g0, g1;
        logic [W-1:0] v50;
        rst = 1'b0; clr_start = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < D; i++) begin
            mem[i] = $urandom | 32'h1;
            ref_mem[i] = mem[i];
        end
        tick();
        tick();
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk_en = 1;
        rst = 1'b1;

        // 1: write then read-back
        access(0, 1'b1, 5, 32'hDEAD_BEEF);
        read_chk(0, 5, 32'hDEAD_BEEF);

        // 2: both masters read continuously -> strict alternation from prio=0
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 10;
        m1_req = 1; m1_we = 0; m1_addr = 11;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("t2_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
            chk("t2_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
            tick();
        end
        m0_req = 0; m1_req = 0;

        // 3: m1 alone twice, then both -> m0 wins
        access(1, 1'b0, 20, '0);
        access(1, 1'b0, 21, '0);
        m0_req = 1; m0_we = 0; m0_addr = 22;
        m1_req = 1; m1_we = 0; m1_addr = 23;
        @(negedge CLK);
        chk("t3_m0_wins", 32'(m0_gnt), 32'd1);
        chk("t3_m1_loses", 32'(m1_gnt), 32'd0);
        tick();
        m0_req = 0;
        @(negedge CLK);
        chk("t3_m1_next", 32'(m1_gnt), 32'd1);
        tick();
        m1_req = 0;

        // 4: full clear
        access(0, 1'b1, 0, 32'h1111_0000);
        access(1, 1'b1, 50, 32'h5050_5050);
        access(0, 1'b1, 99, 32'h9999_9999);
        pulse_clear();
        cnt = 0; dn = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (clr_busy) cnt++;
            if (clr_done) begin dn++; break; end
        end
        chk("t4_busy_len", 32'(cnt), 32'd100);
        chk("t4_done_seen", 32'(dn), 32'd1);
        @(negedge CLK);
        chk("t4_done_1cyc", 32'(clr_done), 32'd0);
        tick();
        read_chk(0, 0, 32'd0);
        read_chk(1, 50, 32'd0);
        read_chk(0, 99, 32'd0);

        // 5: req held through clear, clr_start re-pulsed mid-clear
        pulse_clear();
        m0_req = 1; m0_we = 0; m0_addr = 7;
        cnt = 0; g0 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (m0_gnt) begin
                g0 = 1;
                chk("t5_gnt_on_done", 32'(clr_done), 32'd1);
                chk("t5_busy_at_gnt", 32'(clr_busy), 32'd0);
                break;
            end
            if (clr_busy) cnt++;
            tick();
            clr_start = (cnt == 30);
        end
        chk("t5_busy_len", 32'(cnt), 32'd100);
        chk("t5_gnt_seen", 32'(g0), 32'd1);
        tick();
        m0_req = 0; clr_start = 0;

        // 6: reset in the middle of a clear
        for (int i = 0; i < 45; i++) access(i % 2, 1'b1, i, 32'hA000_0000 + i);
        v50 = 32'hCAFE_0050;
        access(1, 1'b1, 50, v50);
        access(0, 1'b1, 60, 32'hCAFE_0060);
        pulse_clear();
        cnt = 0;
        for (int i = 0; i < 300 && cnt < 40; i++) begin
            @(negedge CLK);
            if (clr_busy) cnt++;
        end
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge CLK);
        chk("t6_busy_after_rst", 32'(clr_busy), 32'd0);
        tick();
        for (int a = 0; a < 40; a++) read_chk(a % 2, a, 32'd0);
        read_chk(0, 50, v50);
        read_chk(1, 60, 32'hCAFE_0060);
        m0_req = 1; m0_we = 0; m0_addr = 1;
        m1_req = 1; m1_we = 0; m1_addr = 2;
        @(negedge CLK);
        chk("t6_prio0_m0", 32'(m0_gnt), 32'd1);
        tick();
        m0_req = 0; m1_req = 0;

        // random traffic with occasional clears
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            g0 = m0_gnt; g1 = m1_gnt;
            tick();
            if (g0) m0_req = 0;
            if (g1) m1_req = 0;
            if (!m0_req && $urandom_range(0, 2) != 0) begin
                m0_req = 1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = AW'($urandom_range(0, D - 1)); m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 2) != 0) begin
                m1_req = 1; m1_we = 1'($urandom_range(0, 1));
                m1_addr = AW'($urandom_range(0, D - 1)); m1_wdata = $urandom;
            end
            clr_start = ($urandom_range(0, 199) == 0);
        end
        m0_req = 0; m1_req = 0; clr_start = 0;
        for (int i = 0; i < 120; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
